// File: rtl/sf_norm_stream_if.sv
// Stream interface for the softermax normaliser: element input side and
// probability output side, both valid/ready.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; a source holds its payload stable while valid is high and ready
// is low, and ready may change freely without waiting for valid.
interface sf_norm_stream_if #(
   parameter int DATA_SIZE = 16,
   parameter int ROW_WIDTH = 8,
   parameter int MAX_W     = 8
);
   localparam int LEN_W = $clog2(ROW_WIDTH + 1);
   localparam int IDX_W = $clog2(ROW_WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [DATA_SIZE-1:0] in_data;
   logic [MAX_W-1:0]     in_max;
   logic [LEN_W-1:0]     row_len;
   logic                 out_valid;
   logic                 out_ready;
   logic [DATA_SIZE-1:0] out_data;
   logic [IDX_W-1:0]     out_idx;
   logic                 out_last;

   modport master (
      output in_valid, in_data, in_max, row_len, out_ready,
      input  in_ready, out_valid, out_data, out_idx, out_last
   );

   modport slave (
      input  in_valid, in_data, in_max, row_len, out_ready,
      output in_ready, out_valid, out_data, out_idx, out_last
   );
endinterface

// File: rtl/sf_norm_stream.sv
// Streaming softermax normaliser. Accumulates a row of (e_i, m_i) with an
// online max and rescaled running sum, computes R = floor(2^(LARGE_SIZE-1)/sum)
// with a restoring divider, then streams p_i = (a_i * R) >> (LARGE_SIZE-DATA_SIZE).
// Optional macro SF_NORM_ROUND_EN: round-half-up on p_i instead of truncation.
// dbg_state exposes the FSM state (0 IDLE, 1 ACCUM, 2 RECIP, 3 OUT).
module sf_norm_stream #(
   parameter int DATA_SIZE  = 16,
   parameter int LARGE_SIZE = 32,
   parameter int ROW_WIDTH  = 8,
   parameter int MAX_W      = 8
) (
   input  logic            clk,
   input  logic            rst,
   sf_norm_stream_if.slave bus,
   output logic            busy,
   output logic [1:0]      dbg_state
);
   localparam int LEN_W  = $clog2(ROW_WIDTH + 1);
   localparam int IDX_W  = $clog2(ROW_WIDTH);
   localparam int DCNT_W = $clog2(LARGE_SIZE);
   localparam int SHIFT  = LARGE_SIZE - DATA_SIZE;
   localparam int PROD_W = DATA_SIZE + LARGE_SIZE;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCUM = 2'd1, S_RECIP = 2'd2, S_OUT = 2'd3} state_t;

   state_t                state_q, state_d;
   logic [LEN_W-1:0]      len_q, len_d, cnt_q, cnt_d, rd_q, rd_d;
   logic [LARGE_SIZE-1:0] sum_q, sum_d, rem_q, rem_d, quo_q, quo_d;
   logic [MAX_W-1:0]      max_q, max_d;
   logic [DCNT_W-1:0]     dcnt_q, dcnt_d;
   logic [DATA_SIZE-1:0]  e_buf_q [ROW_WIDTH];
   logic [DATA_SIZE-1:0]  e_buf_d [ROW_WIDTH];
   logic [MAX_W-1:0]      m_buf_q [ROW_WIDTH];
   logic [MAX_W-1:0]      m_buf_d [ROW_WIDTH];
   logic                  in_ready_q, in_ready_d, busy_q, busy_d;
   logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
   logic [DATA_SIZE-1:0]  out_data_q, out_data_d;
   logic [IDX_W-1:0]      out_idx_q, out_idx_d;

   logic                  accept;
   logic [LEN_W-1:0]      len_clamp;
   logic signed [MAX_W:0] mdiff;
   logic [MAX_W:0]        up_sh, dn_sh, out_sh;
   logic [LARGE_SIZE:0]   acc, rem_sh;
   logic [LARGE_SIZE-1:0] acc_sum, rem_sub;
   logic [MAX_W-1:0]      acc_max;
   logic                  quo_bit;
   logic [IDX_W-1:0]      ridx;
   logic [DATA_SIZE-1:0]  a_val, p_val;
   logic [PROD_W-1:0]     prod, prod_sh;

   // Datapath: online max/sum update, one restoring-divider step, probability of element rd_q.
   always_comb begin
      accept    = bus.in_valid & in_ready_q;
      len_clamp = ((bus.row_len == '0) || (bus.row_len > LEN_W'(ROW_WIDTH))) ? LEN_W'(ROW_WIDTH) : bus.row_len;
      // Max difference at MAX_W+1 bits so extreme signed maxima cannot wrap.
      mdiff = $signed({bus.in_max[MAX_W-1], bus.in_max}) - $signed({max_q[MAX_W-1], max_q});
      up_sh = mdiff;
      dn_sh = -mdiff;
      if (!mdiff[MAX_W] && (mdiff != '0)) begin
         acc     = {1'b0, sum_q >> up_sh} + {{(LARGE_SIZE + 1 - DATA_SIZE){1'b0}}, bus.in_data};
         acc_max = bus.in_max;
      end else begin
         acc     = {1'b0, sum_q} + {{(LARGE_SIZE + 1 - DATA_SIZE){1'b0}}, bus.in_data >> dn_sh};
         acc_max = max_q;
      end
      acc_sum = acc[LARGE_SIZE] ? '1 : acc[LARGE_SIZE-1:0];

      // Dividend is 2^(LARGE_SIZE-1): its only set bit enters on the first step.
      rem_sh  = {rem_q, (dcnt_q == '0)};
      quo_bit = (rem_sh >= {1'b0, sum_q});
      rem_sub = quo_bit ? (rem_sh[LARGE_SIZE-1:0] - sum_q) : rem_sh[LARGE_SIZE-1:0];

      ridx    = rd_q[IDX_W-1:0];
      out_sh  = $signed({max_q[MAX_W-1], max_q}) - $signed({m_buf_q[ridx][MAX_W-1], m_buf_q[ridx]});
      a_val   = e_buf_q[ridx] >> out_sh;
      prod    = {{LARGE_SIZE{1'b0}}, a_val} * {{DATA_SIZE{1'b0}}, quo_q};
`ifdef SF_NORM_ROUND_EN
      prod    = prod + (PROD_W'(1) << (SHIFT - 1));
`else
      prod    = prod + '0;
`endif
      prod_sh = prod >> SHIFT;
      p_val   = (|prod_sh[PROD_W-1:DATA_SIZE]) ? '1 : prod_sh[DATA_SIZE-1:0];
   end

   // Next-state and next-output logic for IDLE -> ACCUM -> RECIP -> OUT -> IDLE.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      sum_d       = sum_q;
      max_d       = max_q;
      rem_d       = rem_q;
      quo_d       = quo_q;
      dcnt_d      = dcnt_q;
      e_buf_d     = e_buf_q;
      m_buf_d     = m_buf_q;
      in_ready_d  = in_ready_q;
      busy_d      = busy_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      out_data_d  = out_data_q;
      out_idx_d   = out_idx_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               e_buf_d[0] = bus.in_data;
               m_buf_d[0] = bus.in_max;
               sum_d      = {{(LARGE_SIZE - DATA_SIZE){1'b0}}, bus.in_data};
               max_d      = bus.in_max;
               len_d      = len_clamp;
               cnt_d      = LEN_W'(1);
               busy_d     = 1'b1;
               rem_d      = '0;
               quo_d      = '0;
               dcnt_d     = '0;
               if (len_clamp == LEN_W'(1)) begin
                  state_d    = S_RECIP;
                  in_ready_d = 1'b0;
               end else begin
                  state_d = S_ACCUM;
               end
            end
         end
         S_ACCUM: begin
            if (accept) begin
               e_buf_d[cnt_q[IDX_W-1:0]] = bus.in_data;
               m_buf_d[cnt_q[IDX_W-1:0]] = bus.in_max;
               sum_d = acc_sum;
               max_d = acc_max;
               cnt_d = cnt_q + LEN_W'(1);
               if (cnt_q + LEN_W'(1) == len_q) begin
                  state_d    = S_RECIP;
                  in_ready_d = 1'b0;
               end
            end
         end
         S_RECIP: begin
            if (sum_q == '0) begin
               // Nothing to normalise: R stays 0 so every p_i comes out 0.
               quo_d   = '0;
               rd_d    = '0;
               state_d = S_OUT;
            end else begin
               rem_d  = rem_sub;
               quo_d  = {quo_q[LARGE_SIZE-2:0], quo_bit};
               dcnt_d = dcnt_q + DCNT_W'(1);
               if (dcnt_q == DCNT_W'(LARGE_SIZE - 1)) begin
                  rd_d    = '0;
                  state_d = S_OUT;
               end
            end
         end
         S_OUT: begin
            if (!out_valid_q || bus.out_ready) begin
               if (out_valid_q && out_last_q) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  out_data_d  = '0;
                  out_idx_d   = '0;
                  in_ready_d  = 1'b1;
                  busy_d      = 1'b0;
                  cnt_d       = '0;
                  sum_d       = '0;
                  max_d       = '0;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = p_val;
                  out_idx_d   = ridx;
                  out_last_d  = (rd_q == len_q - LEN_W'(1));
                  rd_d        = rd_q + LEN_W'(1);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and registered outputs; reset aborts any row in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         rd_q        <= '0;
         sum_q       <= '0;
         max_q       <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dcnt_q      <= '0;
         for (int i = 0; i < ROW_WIDTH; i++) begin
            e_buf_q[i] <= '0;
            m_buf_q[i] <= '0;
         end
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         out_data_q  <= '0;
         out_idx_q   <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         rd_q        <= rd_d;
         sum_q       <= sum_d;
         max_q       <= max_d;
         rem_q       <= rem_d;
         quo_q       <= quo_d;
         dcnt_q      <= dcnt_d;
         e_buf_q     <= e_buf_d;
         m_buf_q     <= m_buf_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         out_data_q  <= out_data_d;
         out_idx_q   <= out_idx_d;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_idx   = out_idx_q;
   assign bus.out_last  = out_last_q;
   assign busy          = busy_q;
   assign dbg_state     = state_q;
endmodule
